// File: rtl/sys_bridge_hs_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sys_bridge_hs_if : processor request/ready bus and device select bus     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface sys_bridge_hs_if #(
  parameter int NDEV = 4
);
  logic                   pr_req;
  logic [31:0]            pr_addr;
  logic [31:0]            pr_wdat;
  logic [3:0]             pr_byteen;
  logic [31:0]            pr_rdat;
  logic                   pr_ready;
  logic                   pr_err;
  logic [31:0]            err_addr;
  logic [31:0]            dev_addr;
  logic [31:0]            dev_wdat;
  logic [NDEV-1:0]        dev_sel;
  logic [4*NDEV-1:0]      dev_byteen;
  logic [32*NDEV-1:0]     dev_rdat;
  logic [NDEV-1:0]        dev_ready;

  // Bridge side
  modport slave (
    input  pr_req, pr_addr, pr_wdat, pr_byteen, dev_rdat, dev_ready,
    output pr_rdat, pr_ready, pr_err, err_addr,
           dev_addr, dev_wdat, dev_sel, dev_byteen
  );

  // Processor/device environment side
  modport master (
    output pr_req, pr_addr, pr_wdat, pr_byteen, dev_rdat, dev_ready,
    input  pr_rdat, pr_ready, pr_err, err_addr,
           dev_addr, dev_wdat, dev_sel, dev_byteen
  );
endinterface
`default_nettype wire

// File: rtl/sys_bridge_hs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sys_bridge_hs : windowed processor-to-device bridge with ready/timeout   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sys_bridge_hs #(
  parameter int                 NDEV    = 4,
  parameter logic [32*NDEV-1:0] BASE    = {32'h7f20, 32'h7f10, 32'h7f00, 32'h0},
  parameter logic [32*NDEV-1:0] LIMIT   = {32'h7f24, 32'h7f1c, 32'h7f0c, 32'h3000},
  parameter int                 TIMEOUT = 16
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  sys_bridge_hs_if.slave bus
);
  localparam int            CW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state,    w_state_nxt;
  logic [CW-1:0]   r_cnt,      w_cnt_nxt;
  logic [NDEV-1:0] r_sel,      w_sel_nxt;
  logic [31:0]     r_addr,     w_addr_nxt;
  logic [31:0]     r_wdat,     w_wdat_nxt;
  logic [31:0]     r_rdat,     w_rdat_nxt;
  logic [31:0]     r_err_addr, w_err_addr_nxt;
  logic [3:0]      r_be,       w_be_nxt;
  logic            r_err,      w_err_nxt;

  logic [NDEV-1:0] w_hit_sel;
  logic            w_hit;
  logic            w_ready;
  logic [31:0]     w_dev_rdat;

  // Scan from the top so the lowest matching window wins on overlap
  always_comb begin
    w_hit     = 1'b0;
    w_hit_sel = '0;
    for (int i = NDEV - 1; i >= 0; i--) begin
      if ((bus.pr_addr >= BASE[32*i +: 32]) && (bus.pr_addr < LIMIT[32*i +: 32])) begin
        w_hit     = 1'b1;
        w_hit_sel = NDEV'(1) << i;
      end
    end
  end

  always_comb begin
    w_dev_rdat = '0;
    for (int i = 0; i < NDEV; i++) begin
      if (r_sel[i]) w_dev_rdat = w_dev_rdat | bus.dev_rdat[32*i +: 32];
    end
  end

  assign w_ready = |(bus.dev_ready & r_sel);

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_sel_nxt      = r_sel;
    w_addr_nxt     = r_addr;
    w_wdat_nxt     = r_wdat;
    w_rdat_nxt     = r_rdat;
    w_err_addr_nxt = r_err_addr;
    w_be_nxt       = r_be;
    w_err_nxt      = r_err;
    case (r_state)
      S_IDLE: begin
        if (bus.pr_req) begin
          w_addr_nxt = bus.pr_addr;
          w_wdat_nxt = bus.pr_wdat;
          w_be_nxt   = bus.pr_byteen;
          w_cnt_nxt  = '0;
          w_rdat_nxt = '0;
          if (w_hit) begin
            w_state_nxt = S_BUSY;
            w_sel_nxt   = w_hit_sel;
            w_err_nxt   = 1'b0;
          end else begin
            w_state_nxt    = S_RESP;
            w_err_nxt      = 1'b1;
            w_err_addr_nxt = bus.pr_addr;
          end
        end
      end
      S_BUSY: begin
        // Ready on the final counted cycle still completes normally
        if (w_ready) begin
          w_state_nxt = S_RESP;
          w_sel_nxt   = '0;
          w_err_nxt   = 1'b0;
          w_rdat_nxt  = (r_be == 4'h0) ? w_dev_rdat : 32'h0;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_nxt    = S_RESP;
          w_sel_nxt      = '0;
          w_err_nxt      = 1'b1;
          w_rdat_nxt     = '0;
          w_err_addr_nxt = r_addr;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_rdat_nxt  = '0;
        w_err_nxt   = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_sel_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_sel      <= '0;
      r_addr     <= '0;
      r_wdat     <= '0;
      r_rdat     <= '0;
      r_err_addr <= '0;
      r_be       <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sel      <= w_sel_nxt;
      r_addr     <= w_addr_nxt;
      r_wdat     <= w_wdat_nxt;
      r_rdat     <= w_rdat_nxt;
      r_err_addr <= w_err_addr_nxt;
      r_be       <= w_be_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign bus.pr_ready = (r_state == S_RESP);
  assign bus.pr_err   = (r_state == S_RESP) & r_err;
  assign bus.pr_rdat  = (r_state == S_RESP) ? r_rdat : 32'h0;
  assign bus.err_addr = r_err_addr;
  assign bus.dev_addr = r_addr;
  assign bus.dev_wdat = r_wdat;
  assign bus.dev_sel  = r_sel;

  generate
    for (genvar g = 0; g < NDEV; g++) begin : g_byteen
      assign bus.dev_byteen[4*g +: 4] = r_sel[g] ? r_be : 4'h0;
    end
  endgenerate
endmodule
`default_nettype wire

// File: tb/tb_sys_bridge_hs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sys_bridge_hs : directed and random accesses against a window model   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_sys_bridge_hs;
  localparam int NDEV = 4;
  localparam int T    = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sys_bridge_hs_if #(.NDEV(NDEV)) bus ();

  sys_bridge_hs #(.NDEV(NDEV), .TIMEOUT(T)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_err_addr = 32'h0;

  longint unsigned win_base [NDEV] = '{64'h0,    64'h7f00, 64'h7f10, 64'h7f20};
  longint unsigned win_lim  [NDEV] = '{64'h3000, 64'h7f0c, 64'h7f1c, 64'h7f24};

  function automatic int slot_of(input logic [31:0] a);
    for (int i = 0; i < NDEV; i++)
      if (64'(a) >= win_base[i] && 64'(a) < win_lim[i]) return i;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // dly = index of the BUSY cycle in which the device raises ready (>= T: never)
  task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                        input int dly, input logic [31:0] rd);
    int                slot, lat, busy, exp_lat, exp_busy;
    logic              exp_err, got_err;
    logic [31:0]       exp_rdat, got_rdat;
    logic [NDEV-1:0]   exp_sel;
    logic [4*NDEV-1:0] exp_be;
    bit                done, bad_sel, bad_idle;
    slot = slot_of(a);
    if (slot < 0) begin
      exp_lat = 1; exp_busy = 0; exp_err = 1'b1; exp_rdat = 32'h0;
    end else if (dly < T) begin
      exp_lat = dly + 2; exp_busy = dly + 1; exp_err = 1'b0;
      exp_rdat = (be == 4'h0) ? rd : 32'h0;
    end else begin
      exp_lat = T + 1; exp_busy = T; exp_err = 1'b1; exp_rdat = 32'h0;
    end
    exp_sel = '0;
    exp_be  = '0;
    if (slot >= 0) begin
      exp_sel[slot]       = 1'b1;
      exp_be[4*slot +: 4] = be;
    end

    @(negedge clk);
    bus.pr_req    = 1'b1;
    bus.pr_addr   = a;
    bus.pr_wdat   = wd;
    bus.pr_byteen = be;
    bus.dev_ready = '0;
    for (int i = 0; i < NDEV; i++)
      bus.dev_rdat[32*i +: 32] = (i == slot) ? rd : $urandom();

    lat = 0; busy = 0; done = 0; bad_sel = 0; bad_idle = 0;
    got_err = 1'b0; got_rdat = 32'h0;
    while (!done && lat < 4*T) begin
      @(posedge clk); #1;
      lat++;
      if (bus.pr_ready === 1'b1) begin
        done     = 1;
        got_err  = bus.pr_err;
        got_rdat = bus.pr_rdat;
        bus.pr_req    = 1'b0;
        bus.dev_ready = '0;
      end else begin
        if (bus.pr_rdat !== 32'h0 || bus.pr_err !== 1'b0) bad_idle = 1;
        if (bus.dev_sel !== '0) begin
          if (bus.dev_sel !== exp_sel || bus.dev_byteen !== exp_be ||
              bus.dev_addr !== a || bus.dev_wdat !== wd) bad_sel = 1;
          busy++;
          bus.dev_ready = NDEV'($urandom()) & ~exp_sel;
          if (slot >= 0 && busy - 1 == dly) bus.dev_ready[slot] = 1'b1;
        end
      end
    end
    bus.pr_req    = 1'b0;
    bus.dev_ready = '0;

    check("completed",    32'(done),     32'h1);
    check("latency",      32'(lat),      32'(exp_lat));
    check("busy_cycles",  32'(busy),     32'(exp_busy));
    check("pr_err",       32'(got_err),  32'(exp_err));
    check("pr_rdat",      got_rdat,      exp_rdat);
    check("dev_bus",      32'(bad_sel),  32'h0);
    check("idle_outputs", 32'(bad_idle), 32'h0);
    if (exp_err) exp_err_addr = a;

    @(posedge clk); #1;
    check("err_addr",     bus.err_addr,        exp_err_addr);
    check("single_pulse", 32'(bus.pr_ready),   32'h0);
    check("sel_cleared",  32'(bus.dev_sel),    32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},  32'(bus.pr_ready),   32'h0);
    check({tag, "_err"},    32'(bus.pr_err),     32'h0);
    check({tag, "_rdat"},   bus.pr_rdat,         32'h0);
    check({tag, "_eaddr"},  bus.err_addr,        32'h0);
    check({tag, "_daddr"},  bus.dev_addr,        32'h0);
    check({tag, "_dwdat"},  bus.dev_wdat,        32'h0);
    check({tag, "_sel"},    32'(bus.dev_sel),    32'h0);
    check({tag, "_be"},     32'(bus.dev_byteen), 32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  be;
    int          r;
    bus.pr_req    = 1'b0;
    bus.pr_addr   = 32'h0;
    bus.pr_wdat   = 32'h0;
    bus.pr_byteen = 4'h0;
    bus.dev_rdat  = '0;
    bus.dev_ready = '0;

    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    access(32'h0000_0100, 32'h0,         4'h0, 0,    32'hDEADBEEF);
    access(32'h0000_7f14, 32'h12345678,  4'hF, 3,    32'hCAFE0001);
    access(32'h0000_7f0c, 32'h0,         4'h0, 0,    32'h11111111);
    access(32'h0000_2ffc, 32'h0,         4'h0, 1,    32'hA5A5_5A5A);
    access(32'h0000_3000, 32'h0,         4'h0, 0,    32'h22222222);
    access(32'h0000_7f20, 32'h55AA55AA,  4'h3, 1000, 32'h33333333);
    access(32'h0000_7f24, 32'h0,         4'h0, 0,    32'h44444444);
    access(32'h0000_7f18, 32'h0,         4'h0, T-1,  32'hBADC0FFE);
    access(32'h0000_7f08, 32'h0,         4'h0, T,    32'h55555555);

    // Reset in the middle of a Timer0 access
    @(negedge clk);
    bus.pr_req    = 1'b1;
    bus.pr_addr   = 32'h0000_7f04;
    bus.pr_wdat   = 32'h0BAD_F00D;
    bus.pr_byteen = 4'hF;
    bus.dev_ready = '0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_sel", 32'(bus.dev_sel), 32'h2);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    bus.pr_req = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("midrst_noready", 32'(bus.pr_ready), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_err_addr = 32'h0;
    access(32'h0000_7f04, 32'h0, 4'h0, 2, 32'h7777_8888);

    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 5));
      if (r < NDEV)
        a = 32'(win_base[r]) + $urandom_range(0, 32'(win_lim[r] - win_base[r]) - 1);
      else
        a = $urandom();
      be = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      access(a, $urandom(), be, int'($urandom_range(0, T + 2)), $urandom());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
